// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin front end that shares one multi-cycle ALU
// among NUM_REQ requesters. One operation is in flight at a time:
// IDLE (arbitrate) -> ISSUE (1-cycle alu_enable) -> WAIT (alu_ready) -> RESP.
// Optional WAIT watchdog: define ALU_SCHEDULER_TIMEOUT_EN.
module alu_scheduler #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [4*NUM_REQ-1:0]     req_opcode,
    input  logic [WIDTH*NUM_REQ-1:0] req_operand_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_operand_b,
    input  logic [5*NUM_REQ-1:0]     req_shift_amount,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic [4:0]               rsp_flags,
    output logic                     alu_enable,
    output logic [3:0]               alu_opcode,
    output logic [WIDTH-1:0]         alu_operand_a,
    output logic [WIDTH-1:0]         alu_operand_b,
    output logic [4:0]               alu_shift_amount,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_carry_flag,
    input  logic                     alu_overflow_flag,
    input  logic                     alu_ready
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       r_state;
    logic [OW-1:0]    r_owner;
    logic [OW-1:0]    r_last_grant;
    logic [3:0]       r_opcode;
    logic [WIDTH-1:0] r_operand_a;
    logic [WIDTH-1:0] r_operand_b;
    logic [4:0]       r_shift_amount;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_flags;

    logic [3:0]       w_op    [NUM_REQ];
    logic [WIDTH-1:0] w_a     [NUM_REQ];
    logic [WIDTH-1:0] w_b     [NUM_REQ];
    logic [4:0]       w_sh    [NUM_REQ];
    logic             w_grant_vld;
    logic [OW-1:0]    w_grant_idx;
    logic             w_hs;
    logic             w_timeout;
    int               w_j;

    // Per-requester view of the packed request buses
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_op[gi] = req_opcode[4*gi +: 4];
        assign w_a[gi]  = req_operand_a[WIDTH*gi +: WIDTH];
        assign w_b[gi]  = req_operand_b[WIDTH*gi +: WIDTH];
        assign w_sh[gi] = req_shift_amount[5*gi +: 5];
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_j         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_j = int'(r_last_grant) + k;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            if (!w_grant_vld && req_valid[OW'(w_j)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = OW'(w_j);
            end
        end
    end

    // Grant is only offered in IDLE; reset also masks it because it is combinational
    assign w_hs      = reset_n && (r_state == S_IDLE) && w_grant_vld;
    assign req_ready = w_hs ? (ONE << w_grant_idx) : '0;

    assign alu_enable       = (r_state == S_ISSUE);
    assign alu_opcode       = r_opcode;
    assign alu_operand_a    = r_operand_a;
    assign alu_operand_b    = r_operand_b;
    assign alu_shift_amount = r_shift_amount;

    assign rsp_valid  = (r_state == S_RESP) ? (ONE << r_owner) : '0;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;

`ifdef ALU_SCHEDULER_TIMEOUT_EN
    logic [3:0] r_wait_cnt;

    // Watchdog: counts WAIT cycles, cleared while issuing so each op starts at 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                r_wait_cnt <= 4'd0;
        else if (r_state == S_ISSUE) r_wait_cnt <= 4'd0;
        else if (r_state == S_WAIT)  r_wait_cnt <= r_wait_cnt + 4'd1;
    end

    // 16th WAIT cycle without alu_ready
    assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == 4'hF);
`else
    assign w_timeout = 1'b0;
`endif

    // Main FSM plus operand/result holding registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_owner        <= '0;
            r_last_grant   <= OW'(NUM_REQ - 1);
            r_opcode       <= '0;
            r_operand_a    <= '0;
            r_operand_b    <= '0;
            r_shift_amount <= '0;
            r_result       <= '0;
            r_flags        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_owner        <= w_grant_idx;
                        r_last_grant   <= w_grant_idx;
                        r_opcode       <= w_op[w_grant_idx];
                        r_operand_a    <= w_a[w_grant_idx];
                        r_operand_b    <= w_b[w_grant_idx];
                        r_shift_amount <= w_sh[w_grant_idx];
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (alu_ready) begin
                        // zero/negative derived here from the captured result
                        r_result <= alu_result;
                        r_flags  <= {1'b0, alu_overflow_flag, alu_carry_flag,
                                     alu_result[WIDTH-1], (alu_result == '0)};
                        r_state  <= S_RESP;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_flags  <= 5'b10000;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[r_owner]) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a small behavioural ALU stub.
// Define ALU_SCHEDULER_TIMEOUT_EN for both files to exercise the watchdog.
module tb_alu_scheduler;
    localparam int W = 32;
    localparam int N = 4;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_EQ  = 4'h8;
    localparam logic [3:0] OP_NOP = 4'hF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [4*N-1:0]   req_opcode;
    logic [W*N-1:0]   req_operand_a, req_operand_b;
    logic [5*N-1:0]   req_shift_amount;
    logic [W-1:0]     rsp_result;
    logic [4:0]       rsp_flags;
    logic             alu_enable;
    logic [3:0]       alu_opcode;
    logic [W-1:0]     alu_operand_a, alu_operand_b;
    logic [4:0]       alu_shift_amount;
    logic [W-1:0]     alu_result = '0;
    logic             alu_carry_flag = 1'b0, alu_overflow_flag = 1'b0, alu_ready = 1'b0;
    logic             stall = 1'b0, late = 1'b0;
    int               checks = 0, errors = 0;

    alu_scheduler #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
        .req_shift_amount(req_shift_amount),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_shift_amount(alu_shift_amount),
        .alu_result(alu_result), .alu_carry_flag(alu_carry_flag),
        .alu_overflow_flag(alu_overflow_flag), .alu_ready(alu_ready)
    );

    // ALU stub: returns {overflow, carry, result}
    function automatic logic [W+1:0] alu_fn(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        r = '0; c = 1'b0; v = 1'b0; s = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                r = a - b; c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_EQ:   r = (a == b) ? W'(1) : '0;
            default: r = '0;
        endcase
        return {v, c, r};
    endfunction

    // ALU responds one cycle after alu_enable unless stalled; 'late' injects a stray ready
    always @(posedge clk) begin
        if (late) begin
            alu_ready <= 1'b1; alu_result <= 32'hDEAD0000;
            alu_carry_flag <= 1'b0; alu_overflow_flag <= 1'b0;
        end else if (alu_enable && !stall) begin
            alu_ready <= 1'b1;
            {alu_overflow_flag, alu_carry_flag, alu_result} <= alu_fn(alu_opcode, alu_operand_a, alu_operand_b);
        end else begin
            alu_ready <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [4:0] sh);
        req_opcode[4*i +: 4]       = op;
        req_operand_a[W*i +: W]    = a;
        req_operand_b[W*i +: W]    = b;
        req_shift_amount[5*i +: 5] = sh;
    endtask

    task automatic wait_ready(input string tag);
        for (int n = 0; n < 30; n++) begin
            if (req_ready != '0) return;
            tick();
        end
        checks++; errors++;
        $error("FAIL %s_ready_timeout observed=0 expected=grant", tag);
    endtask

    task automatic wait_rsp(input string tag);
        for (int n = 0; n < 30; n++) begin
            if (rsp_valid != '0) return;
            tick();
        end
        checks++; errors++;
        $error("FAIL %s_rsp_timeout observed=0 expected=rsp_valid", tag);
    endtask

    task automatic run_op(input string tag, input int i, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh,
                          input logic [W-1:0] exp_res, input logic [4:0] exp_flags);
        set_req(i, op, a, b, sh);
        req_valid = 4'(1) << i;
        #1;
        wait_ready(tag);
        chk({tag, "_grant"}, req_ready, 4'(1) << i);
        tick();
        chk({tag, "_en"}, alu_enable, 1'b1);
        chk({tag, "_op"}, alu_opcode, op);
        chk({tag, "_a"}, alu_operand_a, a);
        chk({tag, "_b"}, alu_operand_b, b);
        chk({tag, "_sh"}, alu_shift_amount, sh);
        req_valid = '0;
        wait_rsp(tag);
        chk({tag, "_rspv"}, rsp_valid, 4'(1) << i);
        chk({tag, "_res"}, rsp_result, exp_res);
        chk({tag, "_flags"}, rsp_flags, exp_flags);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        req_valid = 4'hF;
        req_opcode = '0; req_operand_a = '0; req_operand_b = '0; req_shift_amount = '0;
        rsp_ready = 4'hF;
        repeat (3) @(negedge clk);

        // reset state, with every requester asking
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 4'h0);
        chk("rst_alu_en", alu_enable, 1'b0);
        chk("rst_alu_op", alu_opcode, 4'h0);
        chk("rst_alu_a", alu_operand_a, 32'h0);
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_flags", rsp_flags, 5'h0);
        req_valid = '0;
        reset_n = 1'b1;
        tick();

        // single op with exact latency: accept T, enable T+1, rsp T+3
        set_req(0, OP_ADD, 32'd5, 32'd7, 5'd0);
        req_valid = 4'b0001;
        #1;
        chk("single_ready_T", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        chk("single_en_T1", alu_enable, 1'b1);
        chk("single_ready_busy", req_ready, 4'b0000);
        tick();
        chk("single_en_T2", alu_enable, 1'b0);
        chk("single_rspv_T2", rsp_valid, 4'b0000);
        tick();
        chk("single_rspv_T3", rsp_valid, 4'b0001);
        chk("single_res", rsp_result, 32'd12);
        chk("single_flags", rsp_flags, 5'b00000);
        tick();
        chk("single_rspv_T4", rsp_valid, 4'b0000);

        // flag cases and opcode pass-through
        run_op("sub", 1, OP_SUB, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF, 5'b00110);
        run_op("eq", 2, OP_EQ, 32'd3, 32'd4, 5'd0, 32'h0, 5'b00001);
        run_op("ovf", 3, OP_ADD, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 5'b01010);
        run_op("carry", 0, OP_ADD, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0, 5'b00101);
        run_op("nop", 3, OP_NOP, 32'h0000A5A5, 32'h00005A5A, 5'd31, 32'h0, 5'b00001);

        // response backpressure on requester 2; other rsp_ready bits high
        rsp_ready = 4'b1011;
        set_req(2, OP_ADD, 32'd20, 32'd22, 5'd0);
        set_req(0, OP_ADD, 32'd1, 32'd1, 5'd0);
        req_valid = 4'b0100;
        #1;
        wait_ready("bp");
        chk("bp_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0001;
        wait_rsp("bp");
        chk("bp_rspv0", rsp_valid, 4'b0100);
        chk("bp_res0", rsp_result, 32'd42);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_rspv_hold", rsp_valid, 4'b0100);
            chk("bp_res_hold", rsp_result, 32'd42);
            chk("bp_ready_zero", req_ready, 4'b0000);
        end
        rsp_ready = 4'hF;
        tick();
        chk("bp_idle_rspv", rsp_valid, 4'b0000);
        chk("bp_idle_grant0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_rsp("bp_q");
        chk("bp_q_rspv", rsp_valid, 4'b0001);
        chk("bp_q_res", rsp_result, 32'd2);
        tick();

        // ALU never answers on its own
        stall = 1'b1;
        set_req(3, OP_ADD, 32'd1, 32'd2, 5'd0);
        req_valid = 4'b1000;
        #1;
        wait_ready("to");
        tick();
        req_valid = '0;
        tick();
`ifdef ALU_SCHEDULER_TIMEOUT_EN
        repeat (15) tick();
        chk("to_rspv_early", rsp_valid, 4'b0000);
        tick();
        chk("to_rspv", rsp_valid, 4'b1000);
        chk("to_res", rsp_result, 32'h0);
        chk("to_flags", rsp_flags, 5'b10000);
        tick();
`else
        repeat (40) tick();
        chk("wait_rspv", rsp_valid, 4'b0000);
        chk("wait_en", alu_enable, 1'b0);
        chk("wait_b_stable", alu_operand_b, 32'd2);
        late = 1'b1;
        tick();
        late = 1'b0;
        tick();
        chk("wait_rspv_late", rsp_valid, 4'b1000);
        chk("wait_res_late", rsp_result, 32'hDEAD0000);
        chk("wait_flags_late", rsp_flags, 5'b00010);
        tick();
`endif
        stall = 1'b0;

        // reset while waiting on the ALU
        stall = 1'b1;
        set_req(1, OP_SUB, 32'd9, 32'd4, 5'd3);
        req_valid = 4'b0010;
        #1;
        wait_ready("rmid");
        tick();
        req_valid = '0;
        tick();
        tick();
        req_valid = 4'hF;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmid_req_ready", req_ready, 4'h0);
        chk("rmid_rspv", rsp_valid, 4'h0);
        chk("rmid_en", alu_enable, 1'b0);
        chk("rmid_op", alu_opcode, 4'h0);
        chk("rmid_a", alu_operand_a, 32'h0);
        chk("rmid_b", alu_operand_b, 32'h0);
        chk("rmid_sh", alu_shift_amount, 5'h0);
        chk("rmid_res", rsp_result, 32'h0);
        chk("rmid_flags", rsp_flags, 5'h0);
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        late = 1'b1;
        tick();
        late = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rmid_no_rsp", rsp_valid, 4'h0);
            tick();
        end

        // round robin with everyone asking; first winner after reset is 0
        for (int i = 0; i < N; i++) set_req(i, OP_ADD, 32'(100 * (i + 1)), 32'(i + 1), 5'd0);
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            wait_ready("rr");
            chk("rr_grant", req_ready, 4'(1) << (k % 4));
            tick();
            wait_rsp("rr");
            chk("rr_rspv", rsp_valid, 4'(1) << (k % 4));
            chk("rr_res", rsp_result, 32'(101 * ((k % 4) + 1)));
            tick();
        end
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width, matched to the ALU.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester operation request.
REQ-006 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept, at most one bit high.
REQ-007 SHALL have port req_opcode, input, 4*NUM_REQ bits: packed per-requester opcode (slice i = bits 4i+3:4i).
REQ-008 SHALL have ports req_operand_a and req_operand_b, input, WIDTH*NUM_REQ bits each: packed per-requester operands.
REQ-009 SHALL have port req_shift_amount, input, 5*NUM_REQ bits: packed per-requester shift amount.
REQ-010 SHALL have port rsp_valid, output, NUM_REQ bits: one-hot response to the owning requester.
REQ-011 SHALL have port rsp_ready, input, NUM_REQ bits: per-requester response accept.
REQ-012 SHALL have port rsp_result, output, WIDTH bits: the result of the completed operation.
REQ-013 SHALL have port rsp_flags, output, 5 bits: {err, overflow, carry, negative, zero}.
REQ-014 SHALL have ALU-side outputs alu_enable (1 bit), alu_opcode (4 bits), alu_operand_a and alu_operand_b (WIDTH bits each), and alu_shift_amount (5 bits).
REQ-015 SHALL have ALU-side inputs alu_result (WIDTH bits), alu_carry_flag, alu_overflow_flag and alu_ready (1 bit each).

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-017 In IDLE, SHALL drive req_ready combinationally to the round-robin winner among the req_valid bits, searching from last_grant+1 upward with wrap-around.
REQ-018 On a handshake (req_valid[i] & req_ready[i]), SHALL register owner=i, the opcode, both operands and the shift amount, update last_grant=i, and go to ISSUE.
REQ-019 In ISSUE, SHALL drive alu_enable=1 for exactly one cycle with the registered operands, then go to WAIT.
REQ-020 In WAIT, SHALL hold alu_enable=0 and ALU inputs stable, and when alu_ready=1, capture alu_result, alu_carry_flag and alu_overflow_flag and go to RESP.
REQ-021 SHALL compute the zero and negative flags locally from the captured result (zero = result==0, negative = result[WIDTH-1]), and SHALL NOT use the ALU's lagging zero/negative outputs.
REQ-022 In RESP, SHALL assert rsp_valid[owner] with stable rsp_result and rsp_flags until rsp_ready[owner]=1, then go to IDLE.
REQ-023 Minimum latency SHALL be: accept in cycle T, alu_enable in T+1, capture in T+2, rsp_valid in T+3; the next accept is possible at T+4 at the earliest.
REQ-024 req_ready SHALL be all-zero outside IDLE; requests arriving while busy wait, and no request is dropped or reordered per requester.
REQ-025 A requester that drops req_valid before its grant SHALL lose nothing, since the grant is taken only on a handshake.
REQ-026 rsp_ready on non-owner bits SHALL be ignored.
REQ-027 All opcodes, including NOP (1111), SHALL pass through unmodified; the scheduler never decodes opcodes.
REQ-028 With err=0 in normal operation, rsp_flags[4] SHALL be 0.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, with req_ready, rsp_valid, alu_enable, alu_opcode, alu_operand_a/b, alu_shift_amount, rsp_result and rsp_flags all 0.
REQ-030 On reset, last_grant SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-031 Reset mid-operation SHALL abort the operation with no response issued; a late alu_ready after reset SHALL be ignored in IDLE.

Configuration
REQ-032 Macro ALU_SCHEDULER_TIMEOUT_EN SHALL control the WAIT-state watchdog.
REQ-033 When ALU_SCHEDULER_TIMEOUT_EN is defined, a 4-bit counter SHALL clear on entering WAIT, and if alu_ready is not seen within 16 WAIT cycles, the block SHALL go to RESP with rsp_result=0 and rsp_flags=5'b10000.
REQ-034 When ALU_SCHEDULER_TIMEOUT_EN is undefined, WAIT SHALL last indefinitely, there SHALL be no counter logic, and err is constant 0.

Verification
REQ-035 Single op: req_valid[0], ADD a=5, b=7, ALU model ready next cycle -> rsp_valid=4'b0001 at T+3, rsp_result=12, rsp_flags=00000.
REQ-036 Round-robin: all four req_valid held high for 8 ops -> grant order 0,1,2,3,0,1,2,3, with each response on the matching rsp_valid bit.
REQ-037 Flags: SUB a=0, b=1 -> rsp_result=32'hFFFFFFFF, negative=1, zero=0; then EQ a=3, b=4 -> rsp_result=0, zero=1.
REQ-038 Backpressure: rsp_ready[2]=0 for 5 cycles -> rsp_valid[2] and the rsp_result value held unchanged, req_ready=0 throughout, IDLE entered the cycle after rsp_ready[2]=1.
REQ-039 Reset mid-op: reset_n low during WAIT -> all outputs 0 asynchronously, no rsp_valid after release, and requester 0 wins the next arbitration.
REQ-040 Timeout (ALU_SCHEDULER_TIMEOUT_EN defined): alu_ready held 0 -> rsp_valid after 16 WAIT cycles with rsp_flags=10000 and rsp_result=0.
